// File: rtl/dom_and_pipe.sv
// WIDTH parallel DOM-indep masked AND gadgets of order ORDER with a valid/ready stream interface.
// Define DOM_AND_OUT_REG_EN to register port_c (2-cycle latency, flop-driven output shares).
module dom_and_pipe #(
    parameter int ORDER = 1,
    parameter int WIDTH = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [(ORDER+1)*WIDTH-1:0]           port_a,
    input  logic [(ORDER+1)*WIDTH-1:0]           port_b,
    input  logic [(ORDER*(ORDER+1)/2)*WIDTH-1:0] port_r,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [(ORDER+1)*WIDTH-1:0]           port_c
);
    localparam int N = ORDER + 1;

    // Row-major index of share pair (i,j), i<j, into the randomness words.
    function automatic int pair_idx(input int i, input int j);
        return i * N - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    logic [N*N*WIDTH-1:0] t_d;
    logic [N*N*WIDTH-1:0] t_q;
    logic [N*WIDTH-1:0]   c_s;
    logic                 v1_d;
    logic                 v1_q;
    logic                 accept_s;
    logic                 adv1_s;

    assign accept_s = in_valid && in_ready;

    // Partial products; cross-domain terms blinded with the pair's shared random word.
    always_comb begin
        t_d = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i == j) begin
                    t_d[(i*N+j)*WIDTH +: WIDTH] = port_a[i*WIDTH +: WIDTH] & port_b[i*WIDTH +: WIDTH];
                end else if (i < j) begin
                    t_d[(i*N+j)*WIDTH +: WIDTH] = (port_a[i*WIDTH +: WIDTH] & port_b[j*WIDTH +: WIDTH])
                                                ^ port_r[pair_idx(i, j)*WIDTH +: WIDTH];
                end else begin
                    t_d[(i*N+j)*WIDTH +: WIDTH] = (port_a[i*WIDTH +: WIDTH] & port_b[j*WIDTH +: WIDTH])
                                                ^ port_r[pair_idx(j, i)*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Compression tree fed only by registered terms (glitch barrier).
    always_comb begin
        c_s = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c_s[i*WIDTH +: WIDTH] = c_s[i*WIDTH +: WIDTH] ^ t_q[(i*N+j)*WIDTH +: WIDTH];
            end
        end
    end

    // Stage-1 occupancy: refilled on accept, emptied when its content moves on.
    always_comb begin
        if (accept_s) begin
            v1_d = 1'b1;
        end else if (adv1_s) begin
            v1_d = 1'b0;
        end else begin
            v1_d = v1_q;
        end
    end

    // Term registers load only on accepted beats so randomness is consumed once per beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q  <= '0;
            v1_q <= 1'b0;
        end else begin
            if (accept_s) begin
                t_q <= t_d;
            end
            v1_q <= v1_d;
        end
    end

`ifdef DOM_AND_OUT_REG_EN
    logic [N*WIDTH-1:0] c_q;
    logic               v2_d;
    logic               v2_q;

    assign adv1_s    = !v2_q || out_ready;
    assign in_ready  = !v1_q || adv1_s;
    assign out_valid = v2_q;
    assign port_c    = c_q;

    // Output stage takes stage-1 occupancy whenever it is free or draining.
    always_comb begin
        if (adv1_s) begin
            v2_d = v1_q;
        end else begin
            v2_d = v2_q;
        end
    end

    // Output share register holds port_c stable while back-pressured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q  <= '0;
            v2_q <= 1'b0;
        end else begin
            if (adv1_s && v1_q) begin
                c_q <= c_s;
            end
            v2_q <= v2_d;
        end
    end
`else
    assign adv1_s    = out_ready;
    assign in_ready  = !v1_q || out_ready;
    assign out_valid = v1_q;
    assign port_c    = c_s;
`endif

endmodule
